// File: rtl/wdg_conditioner.sv
// ---------------------------------------------------------------------------
// wdg_conditioner
//
// Front end of the watchdog path. The asynchronous kick line is brought into
// the clock domain through a two-flop synchroniser, then debounced on a slow
// periodic strobe. The block delivers the clean kick level (wdg) and that
// strobe (pulso), which the watchdog uses to qualify wdg. It also flags
// debounced kick edges and can count rejected glitches.
//
// Parameters:
//   TICK_DIV       clocks per pulso strobe (>= 2)
//   DEBOUNCE_TICKS consecutive disagreeing strobe samples needed to toggle wdg (>= 1)
//
// Ports:
//   clk        in   system clock; all logic on its rising edge
//   reset      in   synchronous, active-high; clears all state
//   wdg_raw    in   asynchronous kick line from the supervised processor
//   wdg        out  debounced kick level
//   pulso      out  one-cycle strobe every TICK_DIV clocks
//   kick_rise  out  one-cycle pulse when wdg goes 0->1
//   kick_fall  out  one-cycle pulse when wdg goes 1->0
//   glitch_cnt out  saturating count of rejected glitches
//
// Build option:
//   WDG_GLITCH_CNT_EN  when defined, the glitch counter is built. When it is
//                      not defined, glitch_cnt is tied to zero.
// ---------------------------------------------------------------------------
module wdg_conditioner #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wdg_raw,
    output logic       wdg,
    output logic       pulso,
    output logic       kick_rise,
    output logic       kick_fall,
    output logic [7:0] glitch_cnt
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;

    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    // pulso is registered, so it is set one count early. It is then high
    // in the same cycle in which the prescaler holds TICK_DIV-1.
    localparam logic [PW-1:0] PS_PRE  = PW'(TICK_DIV - 2);
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_TICKS - 1);

    // Synchroniser
    logic s1_q, s2_q;

    // Prescaler
    logic [PW-1:0] ps_q, ps_d;
    logic          pulso_q, pulso_d;

    // Debounce
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          wdg_q, wdg_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        ps_d    = (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
        pulso_d = (ps_q == PS_PRE);
    end

    // The debounce decision is taken only in a strobe cycle. Between strobes,
    // wdg and dcnt hold their values.
    always_comb begin
        wdg_d  = wdg_q;
        dcnt_d = dcnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (pulso_q) begin
            if (s2_q != wdg_q) begin
                if (dcnt_q == DC_LAST) begin
                    wdg_d  = s2_q;
                    dcnt_d = '0;
                    rise_d = s2_q;
                    fall_d = ~s2_q;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end else if (dcnt_q != '0) begin
                // The line agreed with wdg again before the run completed.
                dcnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            ps_q    <= '0;
            pulso_q <= 1'b0;
            dcnt_q  <= '0;
            wdg_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= wdg_raw;
            s2_q    <= s1_q;
            ps_q    <= ps_d;
            pulso_q <= pulso_d;
            dcnt_q  <= dcnt_d;
            wdg_q   <= wdg_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef WDG_GLITCH_CNT_EN
    // A glitch is an aborted run: a strobe sample that agrees with wdg
    // while a disagreeing run is in progress.
    logic       glitch_ev;
    logic [7:0] glitch_q, glitch_d;

    assign glitch_ev = pulso_q && (s2_q == wdg_q) && (dcnt_q != '0);

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_ev && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = 8'd0;
`endif

    assign wdg       = wdg_q;
    assign pulso     = pulso_q;
    assign kick_rise = rise_q;
    assign kick_fall = fall_q;

endmodule
